instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a synchronous instruction memory and buffers
// returned words in a 2-entry queue for decode. Optional perf counters: FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectPC,
    output logic                  IMemReq,
    output logic [ADDR_WIDTH-1:0] IMemAddr,
    input  logic [31:0]           IMemRdata,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [31:0]           Instr,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    output logic [6:0]            Opcode,
    output logic [2:0]            Funct3
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           FlushCount
`endif
);

    // Decode handshake: the head transfers in any cycle where InstrValid and InstrReady are
    // both high. InstrValid never depends on InstrReady; once raised it stays high until the
    // entry is taken, except that a Redirect flushes the queue regardless of the transfer.

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;

    logic [31:0]           fifo_instr [2];
    logic [ADDR_WIDTH-1:0] fifo_pc    [2];
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;

    logic                  pop;
    logic                  issue;
    logic                  fifo_wr;
    logic [2:0]            credit;
    logic [ADDR_WIDTH-1:0] redirect_target;

    assign pop     = InstrValid & InstrReady;
    assign fifo_wr = inflight & ~Redirect;

    // Entries owed to the queue after this cycle: stored + in flight - leaving now.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = reset_n & ~Redirect & (credit < 3'd2);

    assign redirect_target = RedirectPC & ~ADDR_WIDTH'(3);

    assign IMemReq  = issue;
    assign IMemAddr = pc;

    assign InstrValid = (count != 2'd0);
    assign Instr      = fifo_instr[rd_ptr];
    assign InstrPC    = fifo_pc[rd_ptr];
    assign Opcode     = Instr[6:0];
    assign Funct3     = Instr[14:12];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (Redirect) begin
            pc       <= redirect_target;
            inflight <= 1'b0;
        end else if (issue) begin
            pc          <= pc + ADDR_WIDTH'(4);
            inflight    <= 1'b1;
            inflight_pc <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (Redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
            case ({fifo_wr, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says an entry is valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_instr[wr_ptr] <= IMemRdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

    no_overflow_chk : assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_wr && count == 2'd2));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            FetchCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (pop && !Redirect) FetchCount <= FetchCount + 32'd1;
            if (Redirect)         FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: synchronous memory model plus an issue/pop queue reference
// model checked every cycle; covers reset, streaming, stall, redirect, PC wrap, async reset.
module tb_instr_fetch_unit;
  localparam int          AW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          Redirect = 1'b0;
  logic [AW-1:0] RedirectPC = '0;
  logic          IMemReq;
  logic [AW-1:0] IMemAddr;
  logic [31:0]   IMemRdata = '0;
  logic          InstrValid;
  logic          InstrReady = 1'b0;
  logic [31:0]   Instr;
  logic [AW-1:0] InstrPC;
  logic [6:0]    Opcode;
  logic [2:0]    Funct3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   FetchCount;
  logic [31:0]   FlushCount;
`endif

  // clock / reset
  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC),
    .Opcode(Opcode), .Funct3(Funct3)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // synchronous instruction memory; garbage when not requested
  always @(posedge clk) IMemRdata <= IMemReq ? mem_word(IMemAddr) : $urandom();

  // reference model: issue cycles of fetched-but-not-consumed instructions, in order
  int          iss_q[$];
  int          cyc = 10;
  logic [31:0] exp_next;
  logic [31:0] exp_head;
  logic [31:0] fetch_exp;
  logic [31:0] flush_exp;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    iss_q.delete();
    exp_next  = RST_PC;
    exp_head  = RST_PC;
    fetch_exp = 32'd0;
    flush_exp = 32'd0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 32'(IMemReq), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_addr", IMemAddr, RST_PC);
  endtask

  // one clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic rd, input logic [31:0] tgt, input logic rdy);
    bit          ev;
    bit          pm;
    bit          er;
    logic [31:0] w;
    @(negedge clk);
    Redirect   = rd;
    RedirectPC = tgt;
    InstrReady = rdy;
    #1;
    ev = 1'b0;
    if (iss_q.size() > 0) ev = (iss_q[0] <= cyc - 2);
    pm = ev && rdy;
    er = !rd && ((iss_q.size() - int'(pm)) < 2);
    check("valid", 32'(InstrValid), 32'(ev));
    check("req", 32'(IMemReq), 32'(er));
    check("addr", IMemAddr, exp_next);
    if (ev) begin
      w = mem_word(exp_head);
      check("instr_pc", InstrPC, exp_head);
      check("instr", Instr, w);
      check("opcode", 32'(Opcode), 32'(w[6:0]));
      check("funct3", 32'(Funct3), 32'(w[14:12]));
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", FetchCount, fetch_exp);
    check("flush_cnt", FlushCount, flush_exp);
`endif
    if (rd) begin
      iss_q.delete();
      exp_next = tgt & ~32'h3;
      exp_head = exp_next;
      flush_exp++;
    end else begin
      if (pm) begin
        void'(iss_q.pop_front());
        exp_head += 32'd4;
        fetch_exp++;
      end
      if (er) begin
        iss_q.push_back(cyc);
        exp_next += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs();
    end
    @(posedge clk);
    #2 reset_n = 1'b1;

    // streaming
    repeat (10) step(1'b0, 32'h0, 1'b1);
    // stall then resume
    repeat (5) step(1'b0, 32'h0, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    // fill, one pop to put a read in flight, then redirect to an unaligned target
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0203, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1);
    // back-to-back redirects
    repeat (3) step(1'b1, $urandom(), 1'b1);
    repeat (5) step(1'b0, 32'h0, 1'b1);
    // PC wrap across 2^32
    step(1'b1, 32'hFFFF_FFF9, 1'b0);
    repeat (8) step(1'b0, 32'h0, 1'b1);
    // async reset mid-stream
    async_reset_pulse();
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset_pulse();
      step(($urandom_range(0, 9) == 0), $urandom(), ($urandom_range(0, 3) != 0));
    end
    repeat (4) step(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
